// File: rtl/ex_stage.sv
`default_nettype none
// ============================================================================
// Module   : ex_stage
// Purpose  : MIPS execute stage. Holds the ID/EX register and contains the
//            12-op ALU, data-SRAM request generation, forwarding bus, and
//            HI/LO with a 32-iteration restoring divider.
// Revision : 1.0  initial release
// ============================================================================
module ex_stage (
    input  logic         clk,
    input  logic         rst,
    input  logic [5:0]   stall,
    input  logic [158:0] id_to_ex_bus,
    output logic [75:0]  ex_to_mem_bus,
    output logic [75:0]  ex_to_id_bus,
    output logic         data_sram_en,
    output logic [3:0]   data_sram_wen,
    output logic [31:0]  data_sram_addr,
    output logic [31:0]  data_sram_wdata,
    output logic         stallreq
);

    localparam logic [1:0] c_S_IDLE = 2'd0;
    localparam logic [1:0] c_S_RUN  = 2'd1;
    localparam logic [1:0] c_S_DONE = 2'd2;

    localparam logic [5:0] c_F_DIV  = 6'h1A;
    localparam logic [5:0] c_F_DIVU = 6'h1B;
    localparam logic [5:0] c_F_MFHI = 6'h10;
    localparam logic [5:0] c_F_MTHI = 6'h11;
    localparam logic [5:0] c_F_MFLO = 6'h12;
    localparam logic [5:0] c_F_MTLO = 6'h13;

    // ------------------------------------------------------------------
    // ID/EX pipeline register
    // ------------------------------------------------------------------
    logic [158:0] r_id_ex;
    logic         w_bubble;
    logic         w_load;

    assign w_bubble = stall[2] && !stall[3];
    assign w_load   = !stall[2];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_id_ex <= '0;
        end else if (w_bubble) begin
            r_id_ex <= '0;
        end else if (w_load) begin
            r_id_ex <= id_to_ex_bus;
        end
    end

    logic [31:0] w_pc;
    logic [31:0] w_inst;
    logic [11:0] w_alu_op;
    logic [2:0]  w_sel_src1;
    logic [3:0]  w_sel_src2;
    logic        w_ram_en;
    logic [3:0]  w_ram_wen;
    logic        w_rf_we;
    logic [4:0]  w_rf_waddr;
    logic        w_sel_rf_res;
    logic [31:0] w_rdata1;
    logic [31:0] w_rdata2;

    assign {w_pc, w_inst, w_alu_op, w_sel_src1, w_sel_src2, w_ram_en, w_ram_wen,
            w_rf_we, w_rf_waddr, w_sel_rf_res, w_rdata1, w_rdata2} = r_id_ex;

    // ------------------------------------------------------------------
    // Operand selection (one-hot AND-OR; all-zero select yields 0)
    // ------------------------------------------------------------------
    logic [31:0] w_src1;
    logic [31:0] w_src2;

    assign w_src1 = ({32{w_sel_src1[0]}} & w_rdata1)
                  | ({32{w_sel_src1[1]}} & w_pc)
                  | ({32{w_sel_src1[2]}} & {27'd0, w_inst[10:6]});

    assign w_src2 = ({32{w_sel_src2[0]}} & w_rdata2)
                  | ({32{w_sel_src2[1]}} & {{16{w_inst[15]}}, w_inst[15:0]})
                  | ({32{w_sel_src2[2]}} & 32'd8)
                  | ({32{w_sel_src2[3]}} & {16'd0, w_inst[15:0]});

    // ------------------------------------------------------------------
    // ALU
    // ------------------------------------------------------------------
    logic [31:0] w_add_res;
    logic [31:0] w_sub_res;
    logic [31:0] w_slt_res;
    logic [31:0] w_sltu_res;
    logic [31:0] w_sra_res;
    logic [31:0] w_alu_res;

    assign w_add_res  = w_src1 + w_src2;
    assign w_sub_res  = w_src1 - w_src2;
    assign w_slt_res  = {31'd0, ($signed(w_src1) < $signed(w_src2))};
    assign w_sltu_res = {31'd0, (w_src1 < w_src2)};
    assign w_sra_res  = $signed(w_src2) >>> w_src1[4:0];

    assign w_alu_res = ({32{w_alu_op[11]}} & w_add_res)
                     | ({32{w_alu_op[10]}} & w_sub_res)
                     | ({32{w_alu_op[9]}}  & w_slt_res)
                     | ({32{w_alu_op[8]}}  & w_sltu_res)
                     | ({32{w_alu_op[7]}}  & (w_src1 & w_src2))
                     | ({32{w_alu_op[6]}}  & ~(w_src1 | w_src2))
                     | ({32{w_alu_op[5]}}  & (w_src1 | w_src2))
                     | ({32{w_alu_op[4]}}  & (w_src1 ^ w_src2))
                     | ({32{w_alu_op[3]}}  & (w_src2 << w_src1[4:0]))
                     | ({32{w_alu_op[2]}}  & (w_src2 >> w_src1[4:0]))
                     | ({32{w_alu_op[1]}}  & w_sra_res)
                     | ({32{w_alu_op[0]}}  & {w_src2[15:0], 16'd0});

    // ------------------------------------------------------------------
    // Special-op decode (R-type, opcode 0)
    // ------------------------------------------------------------------
    logic w_rtype;
    logic w_is_div;
    logic w_is_divu;
    logic w_is_mfhi;
    logic w_is_mflo;
    logic w_is_mthi;
    logic w_is_mtlo;

    assign w_rtype   = (w_inst[31:26] == 6'd0);
    assign w_is_div  = w_rtype && (w_inst[5:0] == c_F_DIV);
    assign w_is_divu = w_rtype && (w_inst[5:0] == c_F_DIVU);
    assign w_is_mfhi = w_rtype && (w_inst[5:0] == c_F_MFHI);
    assign w_is_mthi = w_rtype && (w_inst[5:0] == c_F_MTHI);
    assign w_is_mflo = w_rtype && (w_inst[5:0] == c_F_MFLO);
    assign w_is_mtlo = w_rtype && (w_inst[5:0] == c_F_MTLO);

    // ------------------------------------------------------------------
    // Divider FSM
    // ------------------------------------------------------------------
    logic [1:0]  r_state;
    logic [1:0]  w_state_nxt;
    logic        r_div_done;
    logic        w_div_start;
    logic [4:0]  r_cnt;
    logic [31:0] r_rem;
    logic [31:0] r_quo;
    logic [31:0] r_dvs;
    logic        r_q_neg;
    logic        r_r_neg;
    logic        r_dz;

    // The done flag keeps a div that is still held in EX after DONE from restarting.
    assign w_div_start = (w_is_div || w_is_divu) && !r_div_done;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_S_IDLE: if (w_div_start) w_state_nxt = c_S_RUN;
            c_S_RUN:  if (r_cnt == 5'd31) w_state_nxt = c_S_DONE;
            c_S_DONE: w_state_nxt = c_S_IDLE;
            default:  w_state_nxt = c_S_IDLE;
        endcase
    end

    always_comb begin
        stallreq = 1'b0;
        case (r_state)
            c_S_IDLE: stallreq = w_div_start;
            c_S_RUN:  stallreq = 1'b1;
            default:  stallreq = 1'b0;
        endcase
    end

    logic        w_a_neg;
    logic        w_b_neg;
    logic [32:0] w_shift;
    logic [33:0] w_trial;

    assign w_a_neg = w_is_div && w_rdata1[31];
    assign w_b_neg = w_is_div && w_rdata2[31];
    assign w_shift = {r_rem, r_quo[31]};
    assign w_trial = {1'b0, w_shift} - {2'b00, r_dvs};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt   <= '0;
            r_rem   <= '0;
            r_quo   <= '0;
            r_dvs   <= '0;
            r_q_neg <= 1'b0;
            r_r_neg <= 1'b0;
            r_dz    <= 1'b0;
        end else begin
            case (r_state)
                c_S_IDLE: begin
                    if (w_div_start) begin
                        r_cnt   <= '0;
                        r_rem   <= '0;
                        r_quo   <= w_a_neg ? (~w_rdata1 + 32'd1) : w_rdata1;
                        r_dvs   <= w_b_neg ? (~w_rdata2 + 32'd1) : w_rdata2;
                        r_q_neg <= w_a_neg ^ w_b_neg;
                        r_r_neg <= w_a_neg;
                        r_dz    <= (w_rdata2 == 32'd0);
                    end
                end
                c_S_RUN: begin
                    r_cnt <= r_cnt + 5'd1;
                    if (!w_trial[33]) begin
                        r_rem <= w_trial[31:0];
                        r_quo <= {r_quo[30:0], 1'b1};
                    end else begin
                        r_rem <= w_shift[31:0];
                        r_quo <= {r_quo[30:0], 1'b0};
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_div_done <= 1'b0;
        end else if (w_bubble || w_load) begin
            r_div_done <= 1'b0;
        end else if (r_state == c_S_DONE) begin
            r_div_done <= 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // HI / LO
    // ------------------------------------------------------------------
    logic [31:0] r_hi;
    logic [31:0] r_lo;
    logic [31:0] w_hi_res;
    logic [31:0] w_lo_res;

    // Divide-by-zero reports the raw dividend, which is still held in the register.
    assign w_lo_res = r_dz ? 32'hFFFF_FFFF : (r_q_neg ? (~r_quo + 32'd1) : r_quo);
    assign w_hi_res = r_dz ? w_rdata1      : (r_r_neg ? (~r_rem + 32'd1) : r_rem);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_hi <= '0;
            r_lo <= '0;
        end else if (r_state == c_S_DONE) begin
            r_hi <= w_hi_res;
            r_lo <= w_lo_res;
        end else if (!stall[2]) begin
            if (w_is_mthi) r_hi <= w_rdata1;
            if (w_is_mtlo) r_lo <= w_rdata1;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    logic [31:0] w_ex_result;

    assign w_ex_result = w_is_mfhi ? r_hi :
                         w_is_mflo ? r_lo : w_alu_res;

    assign ex_to_mem_bus   = {w_pc, w_ram_en, w_ram_wen, w_sel_rf_res, w_rf_we,
                              w_rf_waddr, w_ex_result};
    assign ex_to_id_bus    = ex_to_mem_bus;
    assign data_sram_en    = w_ram_en;
    assign data_sram_wen   = w_ram_wen;
    assign data_sram_addr  = w_alu_res;
    assign data_sram_wdata = w_rdata2;

    logic w_unused;
    assign w_unused = ^{stall[5:4], stall[1:0], w_inst[25:16], w_shift[32], w_trial[32]};

endmodule
`default_nettype wire

// File: tb/tb_ex_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_ex_stage
// Purpose  : Self-checking bench for ex_stage against an arithmetic model.
// Revision : 1.0  initial release
// ============================================================================
module tb_ex_stage;

    logic         clk;
    logic         rst;
    logic [5:0]   ext_stall;
    logic [5:0]   stall;
    logic [158:0] id_to_ex_bus;
    logic [75:0]  ex_to_mem_bus;
    logic [75:0]  ex_to_id_bus;
    logic         data_sram_en;
    logic [3:0]   data_sram_wen;
    logic [31:0]  data_sram_addr;
    logic [31:0]  data_sram_wdata;
    logic         stallreq;

    int n_tests;
    int n_fail;

    // Simple stall controller: a busy divider freezes stages 0..3.
    assign stall = ext_stall | (stallreq ? 6'b001111 : 6'b000000);

    ex_stage dut (
        .clk             (clk),
        .rst             (rst),
        .stall           (stall),
        .id_to_ex_bus    (id_to_ex_bus),
        .ex_to_mem_bus   (ex_to_mem_bus),
        .ex_to_id_bus    (ex_to_id_bus),
        .data_sram_en    (data_sram_en),
        .data_sram_wen   (data_sram_wen),
        .data_sram_addr  (data_sram_addr),
        .data_sram_wdata (data_sram_wdata),
        .stallreq        (stallreq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    // ------------------------------------------------------------------
    // Reference model helpers
    // ------------------------------------------------------------------
    function automatic logic [158:0] mk_bus(
        input logic [31:0] pc, input logic [31:0] inst, input logic [11:0] op,
        input logic [2:0] s1, input logic [3:0] s2, input logic ram_en,
        input logic [3:0] ram_wen, input logic rf_we, input logic [4:0] waddr,
        input logic sel_rf, input logic [31:0] rd1, input logic [31:0] rd2);
        return {pc, inst, op, s1, s2, ram_en, ram_wen, rf_we, waddr, sel_rf, rd1, rd2};
    endfunction

    function automatic logic [75:0] exp_bus(
        input logic [31:0] pc, input logic ram_en, input logic [3:0] ram_wen,
        input logic sel_rf, input logic rf_we, input logic [4:0] waddr,
        input logic [31:0] res);
        return {pc, ram_en, ram_wen, sel_rf, rf_we, waddr, res};
    endfunction

    function automatic logic [31:0] ref_src1(input int k, input logic [31:0] rd1,
                                             input logic [31:0] pc, input logic [31:0] inst);
        case (k)
            1: return rd1;
            2: return pc;
            3: return 32'(inst[10:6]);
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic [31:0] ref_src2(input int k, input logic [31:0] rd2,
                                             input logic [31:0] inst);
        int imm;
        imm = int'($signed(inst[15:0]));
        case (k)
            1: return rd2;
            2: return 32'(imm);
            3: return 32'd8;
            4: return 32'(inst[15:0]);
            default: return 32'd0;
        endcase
    endfunction

    // k: 0 add,1 sub,2 slt,3 sltu,4 and,5 nor,6 or,7 xor,8 sll,9 srl,10 sra,11 lui, else none
    function automatic logic [31:0] ref_alu(input int k, input logic [31:0] a, input logic [31:0] b);
        int sa;
        int sb;
        sa = int'(a);
        sb = int'(b);
        case (k)
            0:  return a + b;
            1:  return a - b;
            2:  return (sa < sb) ? 32'd1 : 32'd0;
            3:  return (a < b) ? 32'd1 : 32'd0;
            4:  return a & b;
            5:  return ~(a | b);
            6:  return a | b;
            7:  return a ^ b;
            8:  return b << (a % 32);
            9:  return b >> (a % 32);
            10: return 32'(sb >>> (a % 32));
            11: return b * 32'd65536;
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic [11:0] op_vec(input int k);
        logic [11:0] v;
        v = 12'd0;
        if (k >= 0 && k < 12) v[11 - k] = 1'b1;
        return v;
    endfunction

    function automatic logic [2:0] s1_vec(input int k);
        logic [2:0] v;
        v = 3'd0;
        if (k >= 1 && k <= 3) v[k - 1] = 1'b1;
        return v;
    endfunction

    function automatic logic [3:0] s2_vec(input int k);
        logic [3:0] v;
        v = 4'd0;
        if (k >= 1 && k <= 4) v[k - 1] = 1'b1;
        return v;
    endfunction

    function automatic logic [63:0] ref_div(input bit is_signed, input logic [31:0] a,
                                            input logic [31:0] b);
        logic [31:0] q;
        logic [31:0] r;
        if (b == 32'd0) begin
            q = 32'hFFFF_FFFF;
            r = a;
        end else if (is_signed && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            q = 32'h8000_0000;
            r = 32'd0;
        end else if (is_signed) begin
            q = 32'(int'(a) / int'(b));
            r = 32'(int'(a) % int'(b));
        end else begin
            q = a / b;
            r = a % b;
        end
        return {r, q};
    endfunction

    function automatic logic [31:0] rtype(input logic [5:0] funct);
        return {6'd0, 5'd4, 5'd5, 5'd0, 5'd0, funct};
    endfunction

    // ------------------------------------------------------------------
    // Scenarios
    // ------------------------------------------------------------------
    task automatic test_reset;
        rst = 1'b1;
        ext_stall = 6'd0;
        id_to_ex_bus = {159{1'b1}};
        repeat (2) @(posedge clk);
        #1;
        n_tests++;
        if (ex_to_mem_bus !== 76'd0 || ex_to_id_bus !== 76'd0) begin
            n_fail++;
            $display("FAIL reset_bus: got %h / %h, want 0", ex_to_mem_bus, ex_to_id_bus);
        end
        n_tests++;
        if ({data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata, stallreq} !== 70'd0) begin
            n_fail++;
            $display("FAIL reset_sram: en=%b wen=%h addr=%h wdata=%h stallreq=%b, want 0",
                     data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata, stallreq);
        end
        rst = 1'b0;
    endtask

    task automatic test_alu_ori;
        logic [31:0] inst;
        inst = {6'h0D, 5'd1, 5'd2, 16'h0034};
        id_to_ex_bus = mk_bus(32'hBFC0_0010, inst, op_vec(6), s1_vec(1), s2_vec(4),
                              1'b0, 4'h0, 1'b1, 5'd2, 1'b0, 32'h0000_1200, 32'h0);
        @(posedge clk);
        #1;
        n_tests++;
        if (ex_to_mem_bus !== exp_bus(32'hBFC0_0010, 1'b0, 4'h0, 1'b0, 1'b1, 5'd2, 32'h0000_1234)) begin
            n_fail++;
            $display("FAIL ori: got %h want result 00001234 rf_we=1", ex_to_mem_bus);
        end
    endtask

    task automatic test_mem_store;
        logic [31:0] inst;
        inst = {6'h2B, 5'd1, 5'd2, 16'hFFFC};
        id_to_ex_bus = mk_bus(32'hBFC0_0020, inst, op_vec(0), s1_vec(1), s2_vec(2),
                              1'b1, 4'hF, 1'b0, 5'd0, 1'b0, 32'h0000_0100, 32'hDEAD_BEEF);
        @(posedge clk);
        #1;
        n_tests++;
        if (data_sram_addr !== 32'h0000_00FC || data_sram_wdata !== 32'hDEAD_BEEF ||
            data_sram_en !== 1'b1 || data_sram_wen !== 4'hF) begin
            n_fail++;
            $display("FAIL store: addr=%h wdata=%h en=%b wen=%h, want 000000fc deadbeef 1 f",
                     data_sram_addr, data_sram_wdata, data_sram_en, data_sram_wen);
        end
    endtask

    task automatic test_alu_random;
        for (int i = 0; i < 60; i++) begin
            int k;
            int k1;
            int k2;
            logic [31:0] pc;
            logic [31:0] inst;
            logic [31:0] rd1;
            logic [31:0] rd2;
            logic [4:0]  wa;
            logic        we;
            logic [31:0] res;
            k  = int'($urandom_range(0, 12));
            k1 = int'($urandom_range(0, 3));
            k2 = int'($urandom_range(0, 4));
            pc = $urandom;
            inst = {6'h08, 26'($urandom)};
            rd1 = (i % 7 == 0) ? 32'h8000_0000 : $urandom;
            rd2 = (i % 5 == 0) ? 32'hFFFF_FFFF : $urandom;
            wa = 5'($urandom);
            we = 1'($urandom);
            res = ref_alu(k, ref_src1(k1, rd1, pc, inst), ref_src2(k2, rd2, inst));
            id_to_ex_bus = mk_bus(pc, inst, op_vec(k), s1_vec(k1), s2_vec(k2),
                                  1'b0, 4'h0, we, wa, 1'b1, rd1, rd2);
            @(posedge clk);
            #1;
            n_tests++;
            if (ex_to_mem_bus !== exp_bus(pc, 1'b0, 4'h0, 1'b1, we, wa, res) ||
                ex_to_id_bus !== ex_to_mem_bus) begin
                n_fail++;
                $display("FAIL alu_rand op=%0d s1=%0d s2=%0d: got %h want result %h",
                         k, k1, k2, ex_to_mem_bus, res);
            end
            n_tests++;
            if (data_sram_addr !== res || data_sram_wdata !== rd2) begin
                n_fail++;
                $display("FAIL alu_rand_sram: addr=%h wdata=%h want %h %h",
                         data_sram_addr, data_sram_wdata, res, rd2);
            end
        end
    endtask

    task automatic test_div_case(input bit is_signed, input logic [31:0] a,
                                 input logic [31:0] b);
        logic [63:0] exp;
        int cyc;
        int bad_bus;
        exp = ref_div(is_signed, a, b);
        id_to_ex_bus = mk_bus(32'hBFC0_0100, rtype(is_signed ? 6'h1A : 6'h1B), 12'd0,
                              3'd0, 4'd0, 1'b0, 4'h0, 1'b0, 5'd0, 1'b0, a, b);
        @(posedge clk);
        #1;
        id_to_ex_bus = mk_bus(32'hBFC0_0104, rtype(6'h12), 12'd0, 3'd0, 4'd0,
                              1'b0, 4'h0, 1'b1, 5'd9, 1'b0, 32'd0, 32'd0);
        cyc = 0;
        bad_bus = 0;
        while (stallreq === 1'b1 && cyc < 100) begin
            if (ex_to_mem_bus[75:44] !== 32'hBFC0_0100 || ex_to_mem_bus[37] !== 1'b0) bad_bus++;
            cyc++;
            @(posedge clk);
            #1;
        end
        n_tests++;
        if (cyc != 33 || bad_bus != 0) begin
            n_fail++;
            $display("FAIL div_stall a=%h b=%h: stall cycles %0d want 33, bad held bus %0d",
                     a, b, cyc, bad_bus);
        end
        @(posedge clk);
        #1;
        n_tests++;
        if (ex_to_mem_bus[31:0] !== exp[31:0] || ex_to_mem_bus[37] !== 1'b1) begin
            n_fail++;
            $display("FAIL div_lo s=%0d a=%h b=%h: got %h want %h",
                     is_signed, a, b, ex_to_mem_bus[31:0], exp[31:0]);
        end
        id_to_ex_bus = mk_bus(32'hBFC0_0108, rtype(6'h10), 12'd0, 3'd0, 4'd0,
                              1'b0, 4'h0, 1'b1, 5'd10, 1'b0, 32'd0, 32'd0);
        @(posedge clk);
        #1;
        n_tests++;
        if (ex_to_mem_bus[31:0] !== exp[63:32]) begin
            n_fail++;
            $display("FAIL div_hi s=%0d a=%h b=%h: got %h want %h",
                     is_signed, a, b, ex_to_mem_bus[31:0], exp[63:32]);
        end
    endtask

    task automatic test_div_signed;
        test_div_case(1'b1, 32'hFFFF_FFF9, 32'd2);
        test_div_case(1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
    endtask

    task automatic test_divu_zero_mthi;
        test_div_case(1'b0, 32'h0000_0010, 32'd0);
        id_to_ex_bus = mk_bus(32'hBFC0_0200, rtype(6'h11), 12'd0, 3'd0, 4'd0,
                              1'b0, 4'h0, 1'b0, 5'd0, 1'b0, 32'h0000_0055, 32'd0);
        @(posedge clk);
        #1;
        id_to_ex_bus = mk_bus(32'hBFC0_0204, rtype(6'h10), 12'd0, 3'd0, 4'd0,
                              1'b0, 4'h0, 1'b1, 5'd3, 1'b0, 32'd0, 32'd0);
        @(posedge clk);
        #1;
        n_tests++;
        if (ex_to_mem_bus[31:0] !== 32'h0000_0055) begin
            n_fail++;
            $display("FAIL mthi_mfhi: got %h want 00000055", ex_to_mem_bus[31:0]);
        end
    endtask

    task automatic test_div_random;
        for (int i = 0; i < 8; i++) begin
            logic [31:0] a;
            logic [31:0] b;
            a = $urandom;
            b = (i == 3) ? 32'd0 : ((i % 2 == 0) ? ($urandom >> $urandom_range(0, 28)) : $urandom);
            test_div_case(1'(i % 2), a, b);
        end
    endtask

    task automatic test_bubble;
        logic [31:0] inst;
        logic [31:0] res;
        inst = {6'h09, 5'd1, 5'd2, 16'h7001};
        res = 32'h1234_0000 + 32'h0000_7001;
        id_to_ex_bus = mk_bus(32'hBFC0_0300, inst, op_vec(0), s1_vec(1), s2_vec(2),
                              1'b0, 4'h0, 1'b1, 5'd7, 1'b0, 32'h1234_0000, 32'd0);
        @(posedge clk);
        #1;
        id_to_ex_bus = mk_bus(32'hBFC0_0304, inst, op_vec(1), s1_vec(1), s2_vec(1),
                              1'b1, 4'h3, 1'b1, 5'd8, 1'b0, 32'd5, 32'd3);
        ext_stall = 6'b000111;
        @(posedge clk);
        #1;
        n_tests++;
        if (ex_to_mem_bus !== 76'd0 || data_sram_en !== 1'b0) begin
            n_fail++;
            $display("FAIL bubble: got %h en=%b want 0", ex_to_mem_bus, data_sram_en);
        end
        ext_stall = 6'd0;
        id_to_ex_bus = mk_bus(32'hBFC0_0300, inst, op_vec(0), s1_vec(1), s2_vec(2),
                              1'b0, 4'h0, 1'b1, 5'd7, 1'b0, 32'h1234_0000, 32'd0);
        @(posedge clk);
        #1;
        id_to_ex_bus = mk_bus(32'hBFC0_0304, inst, op_vec(1), s1_vec(1), s2_vec(1),
                              1'b1, 4'h3, 1'b1, 5'd8, 1'b0, 32'd5, 32'd3);
        ext_stall = 6'b001111;
        repeat (2) @(posedge clk);
        #1;
        n_tests++;
        if (ex_to_mem_bus !== exp_bus(32'hBFC0_0300, 1'b0, 4'h0, 1'b0, 1'b1, 5'd7, res)) begin
            n_fail++;
            $display("FAIL hold: got %h want result %h held", ex_to_mem_bus, res);
        end
        ext_stall = 6'd0;
        @(posedge clk);
        #1;
        n_tests++;
        if (ex_to_mem_bus !== exp_bus(32'hBFC0_0304, 1'b1, 4'h3, 1'b0, 1'b1, 5'd8, 32'd2)) begin
            n_fail++;
            $display("FAIL release: got %h want result 00000002", ex_to_mem_bus);
        end
    endtask

    task automatic test_reset_mid_div;
        id_to_ex_bus = mk_bus(32'd0, rtype(6'h13), 12'd0, 3'd0, 4'd0,
                              1'b0, 4'h0, 1'b0, 5'd0, 1'b0, 32'hAAAA_5555, 32'd0);
        @(posedge clk);
        #1;
        id_to_ex_bus = mk_bus(32'hBFC0_0400, rtype(6'h1A), 12'd0, 3'd0, 4'd0,
                              1'b0, 4'h0, 1'b0, 5'd0, 1'b0, 32'd1000, 32'd7);
        @(posedge clk);
        #1;
        id_to_ex_bus = 159'd0;
        repeat (11) @(posedge clk);
        #1;
        n_tests++;
        if (stallreq !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_div_busy: stallreq=%b want 1", stallreq);
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        n_tests++;
        if (stallreq !== 1'b0 || ex_to_mem_bus !== 76'd0) begin
            n_fail++;
            $display("FAIL mid_div_reset: stallreq=%b bus=%h want 0", stallreq, ex_to_mem_bus);
        end
        id_to_ex_bus = mk_bus(32'hBFC0_0404, rtype(6'h10), 12'd0, 3'd0, 4'd0,
                              1'b0, 4'h0, 1'b1, 5'd1, 1'b0, 32'd0, 32'd0);
        @(posedge clk);
        #1;
        n_tests++;
        if (ex_to_mem_bus[31:0] !== 32'd0 || stallreq !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_div_hi: got %h stallreq=%b want 0", ex_to_mem_bus[31:0], stallreq);
        end
        id_to_ex_bus = mk_bus(32'hBFC0_0408, rtype(6'h12), 12'd0, 3'd0, 4'd0,
                              1'b0, 4'h0, 1'b1, 5'd1, 1'b0, 32'd0, 32'd0);
        @(posedge clk);
        #1;
        n_tests++;
        if (ex_to_mem_bus[31:0] !== 32'd0) begin
            n_fail++;
            $display("FAIL mid_div_lo: got %h want 0", ex_to_mem_bus[31:0]);
        end
    endtask

    initial begin
        n_tests = 0;
        n_fail = 0;
        rst = 1'b1;
        ext_stall = 6'd0;
        id_to_ex_bus = 159'd0;
        test_reset();
        test_alu_ori();
        test_mem_store();
        test_alu_random();
        test_div_signed();
        test_divu_zero_mthi();
        test_div_random();
        test_bubble();
        test_reset_mid_div();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
